// File: rtl/qts_pkg.sv
// qts_pkg: sequencer state encoding and table index/count width helpers.
package qts_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, CHECK, DONE} qts_state_t;

    function automatic int qts_idx_w(input int nload, input int nchk);
        int w;
        w = $clog2(nload > nchk ? nload : nchk);
        return w < 1 ? 1 : w;
    endfunction

    localparam int QTS_NLOAD = 8;
    localparam int QTS_NCHK  = 4;
    localparam int QTS_IDX_W = qts_idx_w(QTS_NLOAD, QTS_NCHK);
    localparam int QTS_CNT_W = QTS_IDX_W + 1;

endpackage

// File: rtl/qts_table.sv
// qts_table: DEPTH x {addr,data} register array, one write port, combinational read.
module qts_table
    import qts_pkg::*;
#(
    parameter int DEPTH = QTS_NLOAD,
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int IW    = QTS_IDX_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [IW-1:0] ridx,
    output logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int TW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [AW+DW-1:0] mem [DEPTH];

    // Contents are deliberately not reset; indices past DEPTH are dropped.
    always_ff @(posedge clk)
        if (we && int'(widx) < DEPTH) mem[widx[TW-1:0]] <= {waddr, wdata};

    assign {raddr, rdata} = mem[ridx[TW-1:0]];

endmodule

// File: rtl/quicktest_sequencer.sv
// quicktest_sequencer: preload memory, run core until done, read back and compare results.
// Optional RUN timeout is compiled in when QTS_TIMEOUT_EN is defined.
module quicktest_sequencer
    import qts_pkg::*;
#(
    parameter int DW      = 8,
    parameter int AW      = 8,
    parameter int NLOAD   = 8,
    parameter int NCHK    = 4,
    parameter int RST_CYC = 2,
    parameter int TIMEOUT = 1024,
    localparam int IW     = qts_idx_w(NLOAD, NCHK),
    localparam int CW     = IW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_we,
    input  logic            cfg_sel,
    input  logic [IW-1:0]   cfg_idx,
    input  logic [AW-1:0]   cfg_addr,
    input  logic [DW-1:0]   cfg_data,
    input  logic            cfg_len_we,
    input  logic [CW-1:0]   cfg_len,
    input  logic            start,
    output logic            core_reset,
    input  logic            core_done,
    output logic            dm_en,
    output logic            dm_we,
    output logic [AW-1:0]   dm_addr,
    output logic [DW-1:0]   dm_wdata,
    input  logic [DW-1:0]   dm_rdata,
    output logic            busy,
    output logic            pass,
    output logic            fail,
    output logic            timed_out,
    output logic [NCHK-1:0] err_mask
);

    localparam int HW = RST_CYC > 1 ? $clog2(RST_CYC) : 1;

    qts_state_t    state, nxt;
    logic [CW-1:0] n_load, n_chk, idx;
    logic [HW-1:0] hcnt;
    logic          cfg_ok, tmo;
    logic [AW-1:0] l_addr, c_addr;
    logic [DW-1:0] l_data, c_data;

    assign cfg_ok = state == IDLE || state == DONE;
    assign busy   = !cfg_ok;

    qts_table #(.DEPTH(NLOAD), .AW(AW), .DW(DW), .IW(IW)) u_load (
        .clk   (clk),
        .we    (cfg_ok && cfg_we && !cfg_sel),
        .widx  (cfg_idx),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .ridx  (idx[IW-1:0]),
        .raddr (l_addr),
        .rdata (l_data)
    );

    qts_table #(.DEPTH(NCHK), .AW(AW), .DW(DW), .IW(IW)) u_chk (
        .clk   (clk),
        .we    (cfg_ok && cfg_we && cfg_sel),
        .widx  (cfg_idx),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .ridx  (idx[IW-1:0]),
        .raddr (c_addr),
        .rdata (c_data)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE: if (start) nxt = n_load == '0 ? HOLD : LOAD;
            LOAD:       if (idx + CW'(1) == n_load) nxt = HOLD;
            HOLD:       if (hcnt == HW'(RST_CYC - 1)) nxt = RUN;
            RUN:        nxt = core_done ? (n_chk == '0 ? DONE : CHECK) : tmo ? DONE : RUN;
            CHECK:      if (idx + CW'(1) == n_chk) nxt = DONE;
            default:    nxt = IDLE;
        endcase
    end

    assign core_reset = state == IDLE || state == LOAD || state == HOLD;
    assign dm_en      = state == LOAD || state == CHECK;
    assign dm_we      = state == LOAD;
    assign dm_addr    = state == LOAD ? l_addr : state == CHECK ? c_addr : '0;
    assign dm_wdata   = dm_we ? l_data : '0;
    assign pass       = state == DONE && !timed_out && err_mask == '0;
    assign fail       = state == DONE && !pass;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            hcnt     <= '0;
            n_load   <= '0;
            n_chk    <= '0;
            err_mask <= '0;
        end else begin
            state <= nxt;
            idx   <= state == nxt && (state == LOAD || state == CHECK) ? idx + CW'(1) : '0;
            hcnt  <= state == HOLD && nxt == HOLD ? hcnt + HW'(1) : '0;
            if (cfg_ok && cfg_len_we && cfg_sel)
                n_chk <= cfg_len > CW'(NCHK) ? CW'(NCHK) : cfg_len;
            if (cfg_ok && cfg_len_we && !cfg_sel)
                n_load <= cfg_len > CW'(NLOAD) ? CW'(NLOAD) : cfg_len;
            if (cfg_ok && start)
                err_mask <= '0;
            else if (state == CHECK && dm_rdata != c_data)
                err_mask <= err_mask | (NCHK'(1) << idx);
        end
    end

`ifdef QTS_TIMEOUT_EN
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] tcnt;

    assign tmo = tcnt == TW'(TIMEOUT - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt      <= '0;
            timed_out <= 1'b0;
        end else begin
            tcnt <= state == RUN && nxt == RUN ? tcnt + TW'(1) : '0;
            if (cfg_ok && start)
                timed_out <= 1'b0;
            else if (state == RUN && tmo && !core_done)
                timed_out <= 1'b1;
        end
    end
`else
    assign tmo       = 1'b0;
    assign timed_out = 1'b0;
`endif

endmodule

// File: tb/tb_quicktest_sequencer.sv
// tb_quicktest_sequencer: directed checks of preload, run, check, reset abort and busy lockout.
module tb_quicktest_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_we = 1'b0, cfg_sel = 1'b0, cfg_len_we = 1'b0, start = 1'b0;
    logic [2:0] cfg_idx = '0;
    logic [7:0] cfg_addr = '0, cfg_data = '0;
    logic [3:0] cfg_len = '0;
    logic       core_reset, core_done, dm_en, dm_we, busy, pass, fail, timed_out;
    logic [7:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0] err_mask;

    logic [7:0] mem [256];
    int         wcount = 0, rcount = 0, rc = 0, run_len = 4;
    logic       cw_en = 1'b0, cd_en = 1'b1;
    logic [7:0] cw_addr = '0, cw_val = '0;
    int         tests = 0, fails = 0;
    int         lat, w0, r0;
    logic       f_busy, f_we, f_cr;
    logic [7:0] f_addr, f_wd;

    always #5 clk = ~clk;

    quicktest_sequencer #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_idx    (cfg_idx),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_len_we (cfg_len_we),
        .cfg_len    (cfg_len),
        .start      (start),
        .core_reset (core_reset),
        .core_done  (core_done),
        .dm_en      (dm_en),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata),
        .busy       (busy),
        .pass       (pass),
        .fail       (fail),
        .timed_out  (timed_out),
        .err_mask   (err_mask)
    );

    // Data memory plus a tiny core: writes cw_val at its 2nd RUN cycle, done on its run_len-th.
    assign dm_rdata  = mem[dm_addr];
    assign core_done = cd_en && !core_reset && rc == run_len - 1;

    always @(posedge clk) begin
        if (dm_en && dm_we) begin
            mem[dm_addr] <= dm_wdata;
            wcount <= wcount + 1;
        end
        if (dm_en && !dm_we) rcount <= rcount + 1;
        rc <= core_reset ? 0 : rc + 1;
        if (!core_reset && rc == 1 && cw_en) mem[cw_addr] <= cw_val;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tab(input bit sel, input int i, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = sel; cfg_idx = 3'(i); cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic len(input bit sel, input int n);
        @(negedge clk);
        cfg_len_we = 1'b1; cfg_sel = sel; cfg_len = 4'(n);
        @(negedge clk);
        cfg_len_we = 1'b0;
    endtask

    // lat = negedges after the start cycle until pass/fail shows; poke tries writes and start while busy.
    task automatic go(input bit poke, output int l);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        l = 1;
        f_busy = busy; f_we = dm_we; f_addr = dm_addr; f_wd = dm_wdata; f_cr = core_reset;
        if (poke) begin
            start = 1'b1; cfg_we = 1'b1; cfg_sel = 1'b1; cfg_idx = 3'd1;
            cfg_addr = 8'd5; cfg_data = 8'h40; cfg_len_we = 1'b1; cfg_len = 4'd1;
        end
        while (!(pass || fail) && l < 200) begin
            @(negedge clk);
            start = 1'b0; cfg_we = 1'b0; cfg_len_we = 1'b0;
            l++;
        end
    endtask

    initial begin
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail", fail, 0);
        chk("rst_dm_en", dm_en, 0);
        chk("rst_err_mask", err_mask, 0);
        chk("rst_timed_out", timed_out, 0);

        // Preload dm[0]=1, dm[1]=2; core writes dm[0]=3; expect dm[0]==3
        tab(0, 0, 8'd0, 8'd1);
        tab(0, 1, 8'd1, 8'd2);
        len(0, 2);
        tab(1, 0, 8'd0, 8'd3);
        len(1, 1);
        cw_en = 1'b1; cw_addr = 8'd0; cw_val = 8'd3; run_len = 4;
        w0 = wcount;
        go(0, lat);
        chk("t1_first_busy", f_busy, 1);
        chk("t1_first_we", f_we, 1);
        chk("t1_first_addr", f_addr, 0);
        chk("t1_first_wdata", f_wd, 1);
        chk("t1_first_core_reset", f_cr, 1);
        chk("t1_latency", lat, 10);
        chk("t1_pass", pass, 1);
        chk("t1_fail", fail, 0);
        chk("t1_err_mask", err_mask, 0);
        chk("t1_writes", wcount - w0, 2);
        chk("t1_mem1", mem[1], 8'd2);
        chk("t1_done_busy", busy, 0);
        chk("t1_done_core_reset", core_reset, 0);
        chk("t1_timed_out", timed_out, 0);

        // Second check entry expects 0x41 where memory holds 0x40
        tab(0, 2, 8'd5, 8'h40);
        len(0, 3);
        tab(1, 1, 8'd5, 8'h41);
        len(1, 2);
        go(0, lat);
        chk("t2_latency", lat, 12);
        chk("t2_fail", fail, 1);
        chk("t2_pass", pass, 0);
        chk("t2_err_mask", err_mask, 4'b0010);

        // Empty tables: only hold, run and the final cycle
        len(0, 0);
        len(1, 0);
        cw_en = 1'b0; run_len = 3;
        w0 = wcount;
        go(0, lat);
        chk("t3_latency", lat, 6);
        chk("t3_pass", pass, 1);
        chk("t3_err_mask", err_mask, 0);
        chk("t3_writes", wcount - w0, 0);

`ifdef QTS_TIMEOUT_EN
        len(1, 2);
        cd_en = 1'b0;
        r0 = rcount;
        go(0, lat);
        chk("t4_latency", lat, 19);
        chk("t4_timed_out", timed_out, 1);
        chk("t4_fail", fail, 1);
        chk("t4_pass", pass, 0);
        chk("t4_reads", rcount - r0, 0);
        cd_en = 1'b1;
`endif

        // Reset asserted after three of eight preload writes
        for (int i = 0; i < 8; i++) tab(0, i, 8'(16 + i), 8'(8'h80 + i));
        len(0, 8);
        w0 = wcount;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t5_core_reset", core_reset, 1);
        chk("t5_busy", busy, 0);
        chk("t5_dm_we", dm_we, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_writes", wcount - w0, 3);
        chk("t5_mem18", mem[18], 8'h82);
        chk("t5_busy_after", busy, 0);
        chk("t5_pass_after", pass, 0);

        // Config writes and start while busy must be ignored
        tab(0, 0, 8'd5, 8'h40);
        len(0, 1);
        tab(1, 0, 8'd0, 8'd3);
        tab(1, 1, 8'd5, 8'h41);
        len(1, 2);
        cw_en = 1'b1; cw_addr = 8'd0; cw_val = 8'd3; run_len = 4;
        go(1, lat);
        chk("t6_latency", lat, 10);
        chk("t6_fail", fail, 1);
        chk("t6_err_mask", err_mask, 4'b0010);
        go(0, lat);
        chk("t6_rerun_latency", lat, 10);
        chk("t6_rerun_err_mask", err_mask, 4'b0010);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/quicktest_sequencer.md
# quicktest_sequencer

Synthesizable self-checking harness that takes over the data-memory port of the single-cycle core (`top_level`). It preloads up to `NLOAD` memory words, holds the core in reset, then releases it and waits for `done`. It then reads back up to `NCHK` result words and compares them against expected values, reporting per-entry pass/fail. It is the parametrised, hardware-resident successor of our milestone quick-test flow and is used on FPGA bring-up and in regression benches.

## Interface
Parameters:
- `DW`, 8, data-memory word width
- `AW`, 8, data-memory address width
- `NLOAD`, 8, preload table depth
- `NCHK`, 4, check table depth (one error bit per entry)
- `RST_CYC`, 2, cycles `core_reset` is held after preload
- `TIMEOUT`, 1024, max RUN cycles (used only with `QTS_TIMEOUT_EN`)

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low
- `cfg_we` in 1: table write strobe
- `cfg_sel` in 1: 0 = preload table, 1 = check table
- `cfg_idx` in clog2(max(NLOAD,NCHK)): table entry
- `cfg_addr` in AW: memory address for the entry
- `cfg_data` in DW: preload value or expected value
- `cfg_len_we` in 1: latch `cfg_len` as the active count of the table selected by `cfg_sel`
- `cfg_len` in clog2(max(NLOAD,NCHK))+1: entry count
- `start` in 1: begin a test
- `core_reset` out 1: active-high reset to core
- `core_done` in 1: core `done`
- `dm_en` out 1: sequencer owns memory port
- `dm_we` out 1: memory write enable
- `dm_addr` out AW
- `dm_wdata` out DW
- `dm_rdata` in DW: asynchronous-read data for `dm_addr`
- `busy` out 1
- `pass` out 1
- `fail` out 1
- `timed_out` out 1
- `err_mask` out NCHK: bit i set if check entry i mismatched

## Operation
- States: IDLE, LOAD, HOLD, RUN, CHECK, DONE.
- IDLE: `core_reset`=1. `cfg_*` writes accepted only in IDLE or DONE and ignored while `busy`. `start` moves to LOAD, or to HOLD if preload count = 0. `start` also clears `pass`, `fail`, `timed_out` and `err_mask`.
- LOAD: one entry per cycle, i = 0..n_load-1. Drives `dm_en`=`dm_we`=1, `dm_addr`=addr[i], `dm_wdata`=data[i]. `core_reset` stays 1. Exits to HOLD after the last entry.
- HOLD: `core_reset`=1 for exactly `RST_CYC` cycles, then RUN.
- RUN: `core_reset`=0, `dm_en`=0 (core owns memory). `core_done`=1 sampled at a clock edge moves to CHECK. Timeout handling per Configuration.
- CHECK: one entry per cycle. Drives `dm_en`=1, `dm_we`=0, `dm_addr`=addr[j]. `dm_rdata` is compared in the same cycle and `err_mask[j]` is set on mismatch. Check count = 0 means CHECK lasts 0 cycles.
- DONE: `pass` = !`timed_out` && `err_mask`==0; `fail` = !`pass`. Results hold until the next `start`. `core_reset` stays 0 until `start`.
- Counts larger than table depth saturate to depth.
- Duplicate addresses in the preload table are written in index order, so the last one wins.
- `start` outside IDLE/DONE is ignored.

## Timing
- Reset values: `core_reset`=1; all other outputs 0. Table counts = 0; table contents are not reset.
- `reset` asserted in any state returns to IDLE asynchronously and aborts the test without a result.
- `busy`=1 from the cycle after `start` through the last CHECK cycle.
- Latency from `start` to `pass`/`fail` valid = n_load + `RST_CYC` + run_cycles + n_chk + 1.
- `core_done` and `start` arriving together in DONE: `start` wins, and `core_done` is ignored outside RUN.

## Configuration
- `QTS_TIMEOUT_EN` defined: a RUN cycle counter of clog2(TIMEOUT) bits is present. After `TIMEOUT` cycles without `core_done`, the sequencer sets `timed_out`, skips CHECK and goes to DONE with `fail`=1.
- `QTS_TIMEOUT_EN` undefined: there is no counter, `timed_out` is tied to 0, and RUN waits indefinitely.

## Structure
- `qts_pkg`: state enum `qts_state_t` and the clog2-derived index/count width constants.
- One sub-module, `qts_table`: a parametrised DEPTH×(AW+DW) register array with a write port and a combinational read. It is instantiated twice, once for preload and once for check.

## Test plan
- Preload dm[0]=1 and dm[1]=2; core model writes dm[0]=3 and raises done; check dm[0]==3 -> `pass`=1, `err_mask`=0.
- Check entries {dm[0]==3, dm[5]==8'h41}; memory holds 8'h40 at address 5 -> `fail`=1, `err_mask`=4'b0010.
- Preload count 0 and check count 0 -> `start` to `pass` in `RST_CYC`+run+1 cycles, with no `dm_we` pulses.
- With `QTS_TIMEOUT_EN` and `TIMEOUT`=16, `core_done` never rises -> `timed_out`=`fail`=1 after 16 RUN cycles, and CHECK issues no reads.
- `reset` low mid-LOAD (after 3 of 8 writes) -> immediately IDLE, `core_reset`=1, `busy`=0, no further writes.
- `cfg_we` while `busy` -> table is unchanged, verified by rerunning and getting identical `err_mask`.
